// File: rtl/sram_banked_dp.sv
// sram_banked_dp: banked two-port SRAM built from 512x32 single-port macros.
// Port 0 reads/writes with byte masks and port 1 is read-only. Requests to
// different banks are served in the same cycle. A same-bank conflict is
// resolved by a ready handshake, so no request is dropped.
// Optional feature macro: SRAM_RR_ARB_EN selects round-robin conflict
// arbitration. When it is undefined, port 0 has fixed priority.

// Behavioural model of the GF180_RAM_512x32 single-port macro.
// CEN is an active-high enable and GWEN is an active-low global write.
// WEN holds active-low byte write enables. Q is registered and is updated
// only by an enabled read.
module gf180_ram_512x32 #(
    parameter int AW = 9,
    parameter int DW = 32,
    parameter int NW = 4
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          gwen,
    input  logic [NW-1:0] wen,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem_r [1<<AW];

    // Storage array and read register; macro contents are never reset.
    always_ff @(posedge clk) begin
        if (cen) begin
            if (!gwen) begin
                for (int i = 0; i < NW; i++) begin
                    if (!wen[i]) begin
                        mem_r[a][8*i +: 8] <= d[8*i +: 8];
                    end
                end
            end else begin
                q <= mem_r[a];
            end
        end
    end
endmodule

module sram_banked_dp #(
    parameter int NUM_WMASKS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MACRO_AW   = 9,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic                  rdy0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic                  rdy1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1
);
    localparam int NUM_BANKS = 1 << (ADDR_WIDTH - MACRO_AW);
    localparam int BANK_W    = (ADDR_WIDTH > MACRO_AW) ? (ADDR_WIDTH - MACRO_AW) : 1;

    logic [BANK_W-1:0]     bank0_s, bank1_s;
    logic                  conflict_s, acc0_s, acc1_s;
    logic [DATA_WIDTH-1:0] q_s [NUM_BANKS];
    logic                  rd0_r, rd1_r;
    logic [BANK_W-1:0]     rbank0_r, rbank1_r;
    logic [DATA_WIDTH-1:0] hold0_r, hold1_r;

    // Bank select comes from the upper address bits. A single-bank build always selects bank 0.
    generate
        if (ADDR_WIDTH > MACRO_AW) begin : g_multi_bank
            assign bank0_s = addr0[ADDR_WIDTH-1:MACRO_AW];
            assign bank1_s = addr1[ADDR_WIDTH-1:MACRO_AW];
        end else begin : g_single_bank
            assign bank0_s = {BANK_W{1'b0}};
            assign bank1_s = {BANK_W{1'b0}};
        end
    endgenerate

    assign conflict_s = !csb0 && !csb1 && (bank0_s == bank1_s);

`ifdef SRAM_RR_ARB_EN
    logic ptr_r;   // 0: port 0 wins the next conflict, 1: port 1 wins

    // On each conflict grant, the round-robin pointer flips to the port that lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_r <= 1'b0;
        end else if (conflict_s) begin
            ptr_r <= ~ptr_r;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign rdy0 = !conflict_s || !ptr_r;
    assign rdy1 = !conflict_s ||  ptr_r;
`else
    assign rdy0 = 1'b1;
    assign rdy1 = !conflict_s;
`endif

    assign acc0_s = !csb0 && rdy0;
    assign acc1_s = !csb1 && rdy1;

    // Each bank is driven by at most one port. A bank with no accepted request stays disabled.
    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic                  cen_s, gwen_s;
            logic [NUM_WMASKS-1:0] wen_s;
            logic [MACRO_AW-1:0]   a_s;
            logic [DATA_WIDTH-1:0] d_s;

            // Route the winning port's request to this bank's macro pins.
            always_comb begin
                cen_s  = 1'b0;
                gwen_s = 1'b1;
                wen_s  = {NUM_WMASKS{1'b1}};
                a_s    = {MACRO_AW{1'b0}};
                d_s    = {DATA_WIDTH{1'b0}};
                if (acc0_s && (bank0_s == BANK_W'(b))) begin
                    cen_s  = 1'b1;
                    gwen_s = web0;
                    wen_s  = web0 ? {NUM_WMASKS{1'b1}} : ~wmask0;
                    a_s    = addr0[MACRO_AW-1:0];
                    d_s    = din0;
                end else if (acc1_s && (bank1_s == BANK_W'(b))) begin
                    cen_s  = 1'b1;
                    gwen_s = 1'b1;
                    a_s    = addr1[MACRO_AW-1:0];
                end else begin
                    cen_s  = 1'b0;
                end
            end

            gf180_ram_512x32 #(
                .AW (MACRO_AW),
                .DW (DATA_WIDTH),
                .NW (NUM_WMASKS)
            ) u_macro (
                .clk  (clk),
                .cen  (cen_s),
                .gwen (gwen_s),
                .wen  (wen_s),
                .a    (a_s),
                .d    (d_s),
                .q    (q_s[b])
            );
        end
    endgenerate

    // Track the accepted reads so that the matching bank's Q is delivered in the next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd0_r    <= 1'b0;
            rd1_r    <= 1'b0;
            rbank0_r <= {BANK_W{1'b0}};
            rbank1_r <= {BANK_W{1'b0}};
        end else begin
            rd0_r    <= acc0_s && web0;
            rd1_r    <= acc1_s;
            rbank0_r <= bank0_s;
            rbank1_r <= bank1_s;
        end
    end

    assign dvalid0 = rd0_r;
    assign dvalid1 = rd1_r;
    assign dout0   = rd0_r ? q_s[rbank0_r] : hold0_r;
    assign dout1   = rd1_r ? q_s[rbank1_r] : hold1_r;

    // Keep a per-port copy of the last delivered word, so the output holds even when the bank is reused.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold0_r <= {DATA_WIDTH{1'b0}};
            hold1_r <= {DATA_WIDTH{1'b0}};
        end else begin
            hold0_r <= dout0;
            hold1_r <= dout1;
        end
    end
endmodule

// File: tb/tb_sram_banked_dp.sv
// Directed testbench for sram_banked_dp. It adapts to SRAM_RR_ARB_EN.
module tb_sram_banked_dp;
    logic        clk = 1'b0;
    logic        resetn;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [10:0] addr0, addr1;
    logic [31:0] din0;
    logic        rdy0, dvalid0, rdy1, dvalid1;
    logic [31:0] dout0, dout1;
    int          tests = 0;
    int          fails = 0;

    sram_banked_dp dut (
        .clk     (clk),
        .resetn  (resetn),
        .csb0    (csb0),
        .web0    (web0),
        .wmask0  (wmask0),
        .addr0   (addr0),
        .din0    (din0),
        .rdy0    (rdy0),
        .dout0   (dout0),
        .dvalid0 (dvalid0),
        .csb1    (csb1),
        .addr1   (addr1),
        .rdy1    (rdy1),
        .dout1   (dout1),
        .dvalid1 (dvalid1)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 11'h000; din0 = 32'h0;
        csb1 = 1'b1; addr1 = 11'h000;
    endtask

    task automatic p0_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    initial begin : stim
        logic exp_rdy0, exp_rdy1, prev_g1;
        resetn = 1'b0;
        idle();
        cyc(); cyc();
        // Check the outputs while reset is held.
        chk("rst_dout0", dout0, 32'h0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_dvalid0", {31'h0, dvalid0}, 32'h0);
        chk("rst_dvalid1", {31'h0, dvalid1}, 32'h0);
        chk("rst_rdy0", {31'h0, rdy0}, 32'h1);
        chk("rst_rdy1", {31'h0, rdy1}, 32'h1);
        resetn = 1'b1;
        cyc();
        chk("rel_dout0", dout0, 32'h0);
        chk("rel_dout1", dout1, 32'h0);
        chk("rel_dvalid", {30'h0, dvalid0, dvalid1}, 32'h0);
        chk("rel_rdy", {30'h0, rdy0, rdy1}, 32'h3);

        // Write DEADBEEF to 0x005, then read it back through port 1.
        p0_write(11'h005, 32'hDEADBEEF, 4'hF);
        #1 chk("wr_rdy0", {31'h0, rdy0}, 32'h1);
        cyc(); idle();
        chk("wr_no_dvalid0", {31'h0, dvalid0}, 32'h0);
        csb1 = 1'b0; addr1 = 11'h005;
        cyc(); idle();
        chk("p1_rd_dvalid", {31'h0, dvalid1}, 32'h1);
        chk("p1_rd_data", dout1, 32'hDEADBEEF);
        cyc();
        chk("p1_hold_dvalid", {31'h0, dvalid1}, 32'h0);
        chk("p1_hold_data", dout1, 32'hDEADBEEF);

        // Seed bank 1 at 0x205 for the parallel-bank test.
        p0_write(11'h205, 32'hCAFEF00D, 4'hF);
        cyc(); idle();

        // A masked write updates bytes 0 and 2 only.
        p0_write(11'h005, 32'h11223344, 4'b0101);
        cyc(); idle();
        csb0 = 1'b0; addr0 = 11'h005;
        cyc(); idle();
        chk("mask_dvalid0", {31'h0, dvalid0}, 32'h1);
        chk("mask_data", dout0, 32'hDE22BE44);
        chk("p1_hold_reuse", dout1, 32'hDEADBEEF);
        chk("p1_hold_reuse_dv", {31'h0, dvalid1}, 32'h0);

        // Reads from both ports to different banks in the same cycle.
        csb0 = 1'b0; addr0 = 11'h005; csb1 = 1'b0; addr1 = 11'h205;
        #1 chk("par_rdy", {30'h0, rdy0, rdy1}, 32'h3);
        cyc(); idle();
        chk("par_dvalid", {30'h0, dvalid0, dvalid1}, 32'h3);
        chk("par_dout0", dout0, 32'hDE22BE44);
        chk("par_dout1", dout1, 32'hCAFEF00D);
        cyc();

        // Same-bank conflict (p0 write 0x010, p1 read 0x020), held for 4 cycles.
        p0_write(11'h010, 32'h0A0B0C0D, 4'hF);
        csb1 = 1'b0; addr1 = 11'h020;
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_RR_ARB_EN
            exp_rdy0 = (k % 2) == 0;
            exp_rdy1 = (k % 2) == 1;
`else
            exp_rdy0 = 1'b1;
            exp_rdy1 = 1'b0;
`endif
            #1;
            chk($sformatf("conf_rdy0_%0d", k), {31'h0, rdy0}, {31'h0, exp_rdy0});
            chk($sformatf("conf_rdy1_%0d", k), {31'h0, rdy1}, {31'h0, exp_rdy1});
            prev_g1 = exp_rdy1;
            cyc();
            chk($sformatf("conf_dvalid1_%0d", k), {31'h0, dvalid1}, {31'h0, prev_g1});
        end
        idle();
        cyc();
        csb0 = 1'b0; addr0 = 11'h010;
        cyc(); idle();
        chk("conf_wr_data", dout0, 32'h0A0B0C0D);

        // Conflicting write and read at the same address: the write is granted first, so the read returns new data.
        p0_write(11'h010, 32'h55AA55AA, 4'hF);
        csb1 = 1'b0; addr1 = 11'h010;
        #1 chk("rw_rdy", {30'h0, rdy0, rdy1}, 32'h2);
        cyc();
        csb0 = 1'b1; web0 = 1'b1;
        #1 chk("rw_rdy1_retry", {31'h0, rdy1}, 32'h1);
        cyc(); idle();
        chk("rw_dvalid1", {31'h0, dvalid1}, 32'h1);
        chk("rw_new_data", dout1, 32'h55AA55AA);
        cyc();

        // Assert reset just after a port-1 read is accepted; the result is discarded.
        csb1 = 1'b0; addr1 = 11'h005;
        cyc(); idle();
        resetn = 1'b0;
        #1;
        chk("mid_rst_dvalid1", {31'h0, dvalid1}, 32'h0);
        chk("mid_rst_dout1", dout1, 32'h0);
        chk("mid_rst_dout0", dout0, 32'h0);
        cyc();
        resetn = 1'b1;
        cyc();
        chk("post_rst_dvalid1", {31'h0, dvalid1}, 32'h0);
        chk("post_rst_dout1", dout1, 32'h0);

        // Memory contents survive reset.
        csb1 = 1'b0; addr1 = 11'h005;
        cyc(); idle();
        chk("retain_data", dout1, 32'hDE22BE44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
